// File: rtl/spike_pkg.sv
// rtl/spike_pkg.sv - shared widths and parameter defaults for the spike event packer
package spike_pkg;

    localparam int TS_W               = 32;
    localparam int DROP_W             = 16;
    localparam int REFRACTORY_DEFAULT = 8;
    localparam int FIFO_DEPTH_DEFAULT = 16;
    localparam int PKT_LEN_DEFAULT    = 4;

    typedef logic [TS_W-1:0]   ts_t;
    typedef logic [DROP_W-1:0] drop_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO, power-of-two depth
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells full from empty when the index bits coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spike_event_packer.sv
// rtl/spike_event_packer.sv - timestamps detector spikes with refractory suppression,
// queues them and streams them out in fixed-length packets
module spike_event_packer
    import spike_pkg::*;
#(
    parameter int REFRACTORY = REFRACTORY_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int PKT_LEN    = PKT_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [TS_W-1:0]   s_axis_data,
    input  logic              s_axis_valid,
    output logic              s_axis_ready,
    output logic [TS_W-1:0]   m_axis_data,
    output logic              m_axis_valid,
    input  logic              m_axis_ready,
    output logic              m_axis_last,
    output logic [DROP_W-1:0] drop_count
);

    localparam int RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    ts_t           sample_cnt;
    logic [RW-1:0] refr_cnt;
    logic [BW-1:0] beat_cnt;
    drop_t         drop_q;
    logic          ready_q;
    logic          spike;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    ts_t           head;
    logic          unused_data_bits;

    assign unused_data_bits = ^s_axis_data[TS_W-1:1];

    assign pop   = !empty && m_axis_ready;
    assign spike = s_axis_valid && s_axis_data[0] && (refr_cnt == '0);
    // A full FIFO still takes the event when the head leaves in the same cycle.
    assign push  = spike && (!full || pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sample_cnt <= '0;
            refr_cnt   <= '0;
            beat_cnt   <= '0;
            drop_q     <= '0;
            ready_q    <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (s_axis_valid) begin
                sample_cnt <= sample_cnt + 1'b1;
                if (spike)
                    refr_cnt <= RW'(REFRACTORY);
                else if (refr_cnt != '0)
                    refr_cnt <= refr_cnt - 1'b1;
            end
            if (spike && !push && (drop_q != '1))
                drop_q <= drop_q + 1'b1;
            if (pop)
                beat_cnt <= (beat_cnt == BW'(PKT_LEN - 1)) ? '0 : beat_cnt + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (sample_cnt),
        .pop    (pop),
        .rdata  (head),
        .full   (full),
        .empty  (empty)
    );

    assign s_axis_ready = ready_q;
    assign m_axis_valid = !empty;
    assign m_axis_data  = head;
    assign m_axis_last  = !empty && (beat_cnt == BW'(PKT_LEN - 1));
    assign drop_count   = drop_q;

endmodule

// File: doc/spike_event_packer.md
SPIKE_EVENT_PACKER -- requirements
Module: spike_event_packer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: ports clk and resetn.
REQ-002 Parameter REFRACTORY, default 8: samples suppressed after an accepted spike; 0 disables suppression.
REQ-003 Parameter FIFO_DEPTH, default 16: event FIFO entries; must be a power of two, minimum 2.
REQ-004 Parameter PKT_LEN, default 4: events per output packet; minimum 1.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 s_axis_data  input  32  detector output word; bit 0 = spike flag; bits 31:1 ignored.
REQ-008 s_axis_valid  input  1  detector word valid.
REQ-009 s_axis_ready  output  1  sample accept.
REQ-010 m_axis_data  output  32  spike timestamp (sample index).
REQ-011 m_axis_valid  output  1  event available.
REQ-012 m_axis_ready  input  1  downstream (DMA) accept.
REQ-013 m_axis_last  output  1  final beat of a PKT_LEN-event packet.
REQ-014 drop_count  output  16  events lost to a full FIFO, saturating.

Function
REQ-015 s_axis_ready SHALL be constant 1 out of reset; the block never stalls the detector.
REQ-016 A sample is accepted on a cycle with s_axis_valid=1.
REQ-017 A 32-bit sample counter SHALL increment by 1 per accepted sample, wrapping 0xFFFFFFFF -> 0x00000000.
REQ-018 The timestamp of a sample SHALL be the counter value before that sample's increment; the first sample after reset has timestamp 0.
REQ-019 A spike is accepted when the sample is accepted, bit 0 = 1, and the refractory counter = 0.
REQ-020 On an accepted spike, the refractory counter SHALL load REFRACTORY; on every other accepted sample it SHALL decrement while nonzero.
REQ-021 Spike flags arriving while the refractory counter is nonzero SHALL be discarded without being counted as drops.
REQ-022 Each accepted spike SHALL push its timestamp into the event FIFO when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-023 Otherwise the event SHALL be discarded, drop_count incremented (saturating at 0xFFFF), and the refractory counter still loaded.
REQ-024 The FIFO SHALL be first-word-fall-through: m_axis_valid = not empty; m_axis_data = head entry.
REQ-025 A pop occurs when m_axis_valid=1 and m_axis_ready=1.
REQ-026 While m_axis_valid=1 and m_axis_ready=0, m_axis_data and m_axis_last SHALL remain stable.
REQ-027 Latency: a spike accepted at edge N into an empty FIFO SHALL present m_axis_valid=1 with its timestamp after edge N (visible in cycle N+1).
REQ-028 A simultaneous push and pop on a non-empty FIFO SHALL leave occupancy unchanged.
REQ-029 A beat counter SHALL count popped events modulo PKT_LEN.
REQ-030 m_axis_last SHALL be 1 when beat counter = PKT_LEN-1 and m_axis_valid=1; with PKT_LEN=1, every beat is last.
REQ-031 Packets SHALL never be padded or truncated; the output waits for further events to complete a packet.

Reset
REQ-032 While resetn=0, asynchronously: m_axis_valid=0, m_axis_last=0, m_axis_data=0, drop_count=0, s_axis_ready=0, FIFO empty, and sample, refractory and beat counters at 0.
REQ-033 Reset mid-operation SHALL discard all queued events and any partial packet; s_axis_ready returns to 1 on the first clock edge after deassertion.

Structure
REQ-034 Package spike_pkg SHALL hold TS_W=32, DROP_W=16 and the default values of REFRACTORY, FIFO_DEPTH and PKT_LEN.
REQ-035 The FIFO SHALL be a sub-module sync_fifo (width, depth parameters; push/pop/full/empty; same clk/resetn); all other logic resides in spike_event_packer.

Verification
REQ-036 Defaults; spike flags on samples 0, 3 and 9, m_axis_ready=1 -> output timestamps 0 and 9 (3 suppressed); drop_count=0.
REQ-037 REFRACTORY=0, PKT_LEN=4; spikes on samples 5, 6, 7, 8, 9 -> timestamps 5, 6, 7, 8 with m_axis_last on 8; 9 pending, m_axis_last=0.
REQ-038 REFRACTORY=0, m_axis_ready=0, 20 consecutive spikes -> 16 queued (timestamps 0-15), drop_count=4; draining yields 0..15 in order.
REQ-039 FIFO full, spike arrives in the same cycle as a pop -> no drop, occupancy stays 16, drop_count unchanged.
REQ-040 Force the sample counter to 0xFFFFFFFE; spikes on the next 3 samples with REFRACTORY=0 -> timestamps 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-041 resetn pulsed low with 5 events queued -> m_axis_valid=0 at once; the next spike after release has timestamp 0.
